flag_branch_ctrl: RTL

- Controller for the pipelined CPU's architectural condition-flag register (N, V, Z, C).
- Owns the enabled flag register and tracks whether the instruction in EX sets flags.
- Resolves B.cond in ID against the flags, either forwarded from EX or taken from the committed register.
- Raises a one-cycle flag-hazard stall when forwarding is disabled, squashes the wrong-path instruction after a taken branch, and counts hazard stalls.

---
 rtl/flag_branch_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/flag_branch_ctrl.sv
// Condition-flag register and B.cond resolution for the pipelined CPU:
// flag forwarding or hazard stall, wrong-path squash, and a stall counter.
module flag_branch_ctrl #(
    parameter bit          EX_FWD = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_ext,
    input  logic             id_valid,
    input  logic             id_setflags,
    input  logic             id_bcond,
    input  logic [3:0]       id_cond,
    input  logic             alu_negative,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    input  logic             alu_carry_out,
    output logic             negative,
    output logic             overflow,
    output logic             zero,
    output logic             carry_out,
    output logic             take_branch,
    output logic             stall_id,
    output logic             kill_id,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        RUN  = 1'b0,
        KILL = 1'b1
    } state_t;

    state_t     state;
    logic       ex_sf;
    logic [3:0] flags;     // {N, V, Z, C}
    logic [3:0] alu_flags;
    logic [3:0] eff;
    logic       n, v, z, c;
    logic       cond_hit;

    assign alu_flags = {alu_negative, alu_overflow, alu_zero, alu_carry_out};
    assign negative  = flags[3];
    assign overflow  = flags[2];
    assign zero      = flags[1];
    assign carry_out = flags[0];

    // Flags seen by B.cond: forwarded from EX when allowed, else committed.
    always_comb begin
        eff = flags;
        if (ex_sf && EX_FWD) begin
            eff = alu_flags;
        end
        {n, v, z, c} = eff;
    end

    always_comb begin
        cond_hit = 1'b0;
        case (id_cond)
            4'b0000: cond_hit = z;
            4'b0001: cond_hit = !z;
            4'b0010: cond_hit = c;
            4'b0011: cond_hit = !c;
            4'b0100: cond_hit = n;
            4'b0101: cond_hit = !n;
            4'b0110: cond_hit = v;
            4'b0111: cond_hit = !v;
            4'b1000: cond_hit = c && !z;
            4'b1001: cond_hit = !(c && !z);
            4'b1010: cond_hit = (n == v);
            4'b1011: cond_hit = (n != v);
            4'b1100: cond_hit = !z && (n == v);
            4'b1101: cond_hit = !(!z && (n == v));
            default: cond_hit = 1'b1;
        endcase
    end

    // Control outputs are held low while reset is asserted.
    always_comb begin
        kill_id     = reset && (state == KILL);
        stall_id    = reset && id_valid && id_bcond && ex_sf && !EX_FWD && !kill_id;
        take_branch = reset && id_valid && id_bcond && !stall_id && !kill_id && cond_hit;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= RUN;
            ex_sf       <= 1'b0;
            flags       <= 4'b0000;
            stall_count <= '0;
        end else if (!stall_ext) begin
            if (ex_sf) begin
                flags <= alu_flags;
            end
            // Stalled or squashed instructions leave a non-flag-setting bubble.
            ex_sf <= id_valid && id_setflags && !stall_id && !kill_id;
            if (stall_id && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            case (state)
                RUN:     state <= take_branch ? KILL : RUN;
                KILL:    state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

endmodule
